// File: rtl/nanosoc_exp_pkg.sv
// Shared encodings for the nanosoc expansion-region interconnect.
package nanosoc_exp_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DT_IDLE = 2'd0,
    DT_ERR1 = 2'd1,
    DT_ERR2 = 2'd2
  } dt_state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/nanosoc_exp_default_target.sv
// Default AHB target: two-cycle ERROR for active transfers and a sticky decode-error log.
module nanosoc_exp_default_target
  import nanosoc_exp_pkg::*;
#(
  parameter int ADDRWIDTH = 29
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 hreadys_i,
  input  logic                 dflt_sel_i,
  input  logic [1:0]           htrans_i,
  input  logic [ADDRWIDTH-1:0] haddr_i,
  input  logic                 err_clr_i,
  output logic                 hreadyout_o,
  output logic                 hresp_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [ADDRWIDTH-1:0] err_addr_o
);

  dt_state_t             state_q, state_d;
  logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic                  active, err_start, enter_err1;

  // IDLE/BUSY to the default target are zero-wait OKAY; only NONSEQ/SEQ error out.
  assign active     = (htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ);
  assign err_start  = hreadys_i & dflt_sel_i & active;
  assign enter_err1 = err_start & ((state_q == DT_IDLE) || (state_q == DT_ERR2));

  // State, error count and error address registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DT_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next state and response outputs of the ERROR sequence.
  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      DT_IDLE: if (err_start) state_d = DT_ERR1;
      DT_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = DT_ERR2;
      end
      DT_ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = err_start ? DT_ERR1 : DT_IDLE;
      end
      default: state_d = DT_IDLE;
    endcase
  end

  // Error log update; a new error in the clear cycle wins and is counted as the first.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (err_clr_i) begin
      cnt_d  = '0;
      addr_d = '0;
    end
    if (enter_err1) begin
      addr_d = haddr_i;
      if (err_clr_i)             cnt_d = ERR_CNT_W'(1);
      else if (cnt_q != '1)      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count_o = cnt_q;
  assign err_addr_o  = addr_q;

endmodule

// File: rtl/nanosoc_exp_region_mux.sv
// Expansion-region interconnect: window decode, data-phase owner tracking, response mux.
module nanosoc_exp_region_mux
  import nanosoc_exp_pkg::*;
#(
  parameter int                   ADDRWIDTH      = 29,
  parameter int                   NUM_PORTS      = 4,
  parameter int                   PORT_ADDRWIDTH = 12,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR      = 29'h0010000,
  parameter logic [7:0]           PORT_ENABLE    = 8'hFF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSELS,
  input  logic [ADDRWIDTH-1:0]      HADDRS,
  input  logic [1:0]                HTRANSS,
  input  logic                      HREADYS,
  output logic                      HREADYOUTS,
  output logic                      HRESPS,
  output logic [31:0]               HRDATAS,
  output logic [NUM_PORTS-1:0]      HSELM,
  input  logic [NUM_PORTS-1:0]      HREADYOUTM,
  input  logic [NUM_PORTS-1:0]      HRESPM,
  input  logic [32*NUM_PORTS-1:0]   HRDATAM,
  input  logic                      err_clr,
  output logic [ERR_CNT_W-1:0]      err_count,
  output logic [ADDRWIDTH-1:0]      err_addr
);

  logic [ADDRWIDTH-1:0] off, idx;
  logic                 in_range, dflt_sel;
  logic [NUM_PORTS:0]   dsel_q, dsel_d;
  logic                 dt_ready, dt_resp;

  // Underflow of the offset is excluded by the in_range term.
  assign off      = HADDRS - BASE_ADDR;
  assign idx      = off >> PORT_ADDRWIDTH;
  assign in_range = (HADDRS >= BASE_ADDR);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
    assign HSELM[gi] = HSELS & in_range & (idx == ADDRWIDTH'(gi)) & PORT_ENABLE[gi];
  end

  assign dflt_sel = HSELS & ~|HSELM;
  assign dsel_d   = HREADYS ? {dflt_sel, HSELM} : dsel_q;

  // Data-phase owner; held while the current owner stalls the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dsel_q <= '0;
    else          dsel_q <= dsel_d;
  end

  nanosoc_exp_default_target #(.ADDRWIDTH(ADDRWIDTH)) u_dflt (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hreadys_i   (HREADYS),
    .dflt_sel_i  (dflt_sel),
    .htrans_i    (HTRANSS),
    .haddr_i     (HADDRS),
    .err_clr_i   (err_clr),
    .hreadyout_o (dt_ready),
    .hresp_o     (dt_resp),
    .err_count_o (err_count),
    .err_addr_o  (err_addr)
  );

  // Response mux; an empty data phase answers ready/OKAY with zero data.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    HRDATAS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dsel_q[i]) begin
        HREADYOUTS = HREADYOUTM[i];
        HRESPS     = HRESPM[i];
        HRDATAS    = HRDATAM[32*i +: 32];
      end
    end
    if (dsel_q[NUM_PORTS]) begin
      HREADYOUTS = dt_ready;
      HRESPS     = dt_resp;
    end
  end

endmodule

// File: tb/tb_nanosoc_exp_region_mux.sv
// Directed bench for the expansion-region interconnect with default parameters.
module tb_nanosoc_exp_region_mux;

  logic         clk, rst_n;
  logic         hsels;
  logic [28:0]  haddrs;
  logic [1:0]   htranss;
  logic         hreadys;
  logic         hreadyouts, hresps;
  logic [31:0]  hrdatas;
  logic [3:0]   hselm;
  logic [3:0]   hreadyoutm, hrespm;
  logic [127:0] hrdatam;
  logic         err_clr;
  logic [7:0]   err_count;
  logic [28:0]  err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  nanosoc_exp_region_mux dut (
    .HCLK(clk), .HRESETn(rst_n), .HSELS(hsels), .HADDRS(haddrs), .HTRANSS(htranss),
    .HREADYS(hreadys), .HREADYOUTS(hreadyouts), .HRESPS(hresps), .HRDATAS(hrdatas),
    .HSELM(hselm), .HREADYOUTM(hreadyoutm), .HRESPM(hrespm), .HRDATAM(hrdatam),
    .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr)
  );

  // Bus HREADY is the interconnect's own muxed ready.
  assign hreadys = hreadyouts;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [28:0] a, input logic [1:0] t);
    hsels = sel; haddrs = a; htranss = t;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; err_clr = 1'b0;
    drive(1'b0, 29'h0, 2'd0);
    hreadyoutm = 4'hF; hrespm = 4'h0;
    hrdatam = {32'h33333333, 32'hCAFEF00D, 32'h11111111, 32'h00000A0A};
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", hreadyouts); end
    n_checks++; if (hresps !== 1'b0) begin n_fail++; $display("FAIL reset_resp got=%b exp=0", hresps); end
    n_checks++; if (hrdatas !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", hrdatas); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", err_count); end
    n_checks++; if (err_addr !== 29'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", err_addr); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_decode;
    logic [28:0] a [6];
    logic [3:0]  e [6];
    a[0] = 29'h0010000; e[0] = 4'b0001;
    a[1] = 29'h0013FFF; e[1] = 4'b1000;
    a[2] = 29'h000FFFF; e[2] = 4'b0000;
    a[3] = 29'h0014000; e[3] = 4'b0000;
    a[4] = 29'h1FFFFFFF; e[4] = 4'b0000;
    a[5] = 29'h0011ABC; e[5] = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, a[k], 2'd0);
      @(negedge clk);
      n_checks++; if (hselm !== e[k]) begin n_fail++; $display("FAIL decode_%0d got=%b exp=%b", k, hselm, e[k]); end
      tick;
    end
    drive(1'b0, 29'h0010000, 2'd2);
    @(negedge clk);
    n_checks++; if (hselm !== 4'b0000) begin n_fail++; $display("FAIL decode_nosel got=%b exp=0", hselm); end
    drive(1'b0, 29'h0, 2'd0);
    tick;
  endtask

  task automatic test_read;
    drive(1'b1, 29'h0012004, 2'd2);
    @(negedge clk);
    n_checks++; if (hselm !== 4'b0100) begin n_fail++; $display("FAIL read_hselm got=%b exp=0100", hselm); end
    tick;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (hrdatas !== 32'hCAFEF00D) begin n_fail++; $display("FAIL read_data got=%h exp=cafef00d", hrdatas); end
    n_checks++; if (hresps !== 1'b0 || hreadyouts !== 1'b1) begin n_fail++; $display("FAIL read_resp got=%b/%b exp=1/0", hreadyouts, hresps); end
    tick;
  endtask

  task automatic test_decode_error;
    drive(1'b1, 29'h0000100, 2'd2);
    tick;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b0 || hresps !== 1'b1) begin n_fail++; $display("FAIL err_c1 got=%b/%b exp=0/1", hreadyouts, hresps); end
    tick;
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b1 || hresps !== 1'b1) begin n_fail++; $display("FAIL err_c2 got=%b/%b exp=1/1", hreadyouts, hresps); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_cnt got=%0d exp=1", err_count); end
    n_checks++; if (err_addr !== 29'h0000100) begin n_fail++; $display("FAIL err_addr got=%h exp=100", err_addr); end
    tick;
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b1 || hresps !== 1'b0) begin n_fail++; $display("FAIL err_idle got=%b/%b exp=1/0", hreadyouts, hresps); end
    tick;
  endtask

  task automatic test_stall;
    drive(1'b1, 29'h0011000, 2'd2);
    tick;
    drive(1'b1, 29'h0010000, 2'd2);
    hreadyoutm = 4'b1101; hrespm = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (hreadyouts !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d got=%b exp=0", k, hreadyouts); end
      n_checks++; if (hrdatas !== 32'h11111111 || hresps !== 1'b0) begin n_fail++; $display("FAIL stall_owner_%0d got=%h/%b exp=11111111/0", k, hrdatas, hresps); end
      tick;
    end
    hreadyoutm = 4'hF;
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b1 || hrdatas !== 32'h11111111) begin n_fail++; $display("FAIL stall_release got=%b/%h exp=1/11111111", hreadyouts, hrdatas); end
    tick;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (hrdatas !== 32'h00000A0A || hresps !== 1'b1) begin n_fail++; $display("FAIL stall_next got=%h/%b exp=00000a0a/1", hrdatas, hresps); end
    hrespm = 4'h0;
    tick;
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    drive(1'b1, 29'h0014000, 2'd2);
    for (int k = 0; k < 300; k++) begin
      tick;
      @(negedge clk);
      if (hreadyouts !== 1'b0 || hresps !== 1'b1) bad++;
      tick;
      if (k == 299) drive(1'b0, 29'h0, 2'd0);
      @(negedge clk);
      if (hreadyouts !== 1'b1 || hresps !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_resp bad_cycles=%0d exp=0", bad); end
    tick;
    @(negedge clk);
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL b2b_sat got=%0d exp=255", err_count); end
    n_checks++; if (err_addr !== 29'h0014000) begin n_fail++; $display("FAIL b2b_addr got=%h exp=14000", err_addr); end
    n_checks++; if (hreadyouts !== 1'b1 || hresps !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b/%b exp=1/0", hreadyouts, hresps); end
    tick;
  endtask

  task automatic test_err_clr;
    drive(1'b1, 29'h0015000, 2'd2);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL clr_win_cnt got=%0d exp=1", err_count); end
    n_checks++; if (err_addr !== 29'h0015000) begin n_fail++; $display("FAIL clr_win_addr got=%h exp=15000", err_addr); end
    tick; tick;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (err_count !== 8'd0 || err_addr !== 29'h0) begin n_fail++; $display("FAIL clr_alone got=%0d/%h exp=0/0", err_count, err_addr); end
    tick;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 29'h0000100, 2'd2);
    tick;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b0) begin n_fail++; $display("FAIL mid_err1 got=%b exp=0", hreadyouts); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (hreadyouts !== 1'b1 || hresps !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got=%b/%b exp=1/0", hreadyouts, hresps); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnt got=%0d exp=0", err_count); end
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    drive(1'b1, 29'h0000100, 2'd0);
    tick;
    drive(1'b0, 29'h0, 2'd0);
    @(negedge clk);
    n_checks++; if (hreadyouts !== 1'b1 || hresps !== 1'b0) begin n_fail++; $display("FAIL idle_dflt got=%b/%b exp=1/0", hreadyouts, hresps); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL idle_dflt_cnt got=%0d exp=0", err_count); end
    tick;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_read;
    test_decode_error;
    test_stall;
    test_back_to_back;
    test_err_clr;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
